imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory writer for the single-cycle MIPS core. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It writes those words sequentially into the instruction memory's write port while holding the processor in reset, then releases the core once the load completes. It is the write side of the instruction memory that the core only reads.

## Interface
- `ADDR_WIDTH`, default 8: word-address width; 8 matches the core's `PC[9:2]` word indexing (256 words).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a load; sampled only in IDLE.
- `word_count` in ADDR_WIDTH+1: number of words to load; sampled with `start`; legal range 0..2^ADDR_WIDTH.
- `rx_data` in 8: stream byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: loader can accept a byte.
- `imem_we` out 1: instruction-memory write enable, one-cycle pulse per word.
- `imem_addr` out ADDR_WIDTH: word address of the current write.
- `imem_wdata` out 32: word being written.
- `cpu_reset` out 1: active-high reset to the core.
- `busy` out 1: load in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `error` out 1: sticky checksum failure; present only with the checksum feature, otherwise tied 0.

## Operation
- States: IDLE, RECV, WRITE, CHECK (checksum builds only), DONE.
- Reset values:
  - state IDLE.
  - `cpu_reset`=1 (core held until the first successful load).
  - `rx_ready`, `imem_we`, `busy`, `done`, `error` = 0.
  - `imem_addr`=0, `imem_wdata`=0.
  - Byte index and word counter = 0.
- IDLE:
  - `start`=1 with `word_count`≠0 → RECV. Latch the count, clear `imem_addr`, the byte index, `error` and the checksum; set `cpu_reset`=1 and `busy`=1.
  - `start`=1 with `word_count`=0 → DONE directly. No writes.
- RECV:
  - `rx_ready`=1.
  - Each accepted byte (`rx_valid`&&`rx_ready`) shifts in MSB-first: byte 0→[31:24], 1→[23:16], 2→[15:8], 3→[7:0].
  - After byte 3 is accepted → WRITE.
  - No byte accepted → state held indefinitely; there is no timeout.
- WRITE:
  - One cycle. `imem_we`=1, `rx_ready`=0.
  - `imem_addr` and `imem_wdata` are stable for the whole cycle.
  - On exit, `imem_addr` increments and the words-written count increments.
  - If words written equals the latched count → CHECK (checksum builds) or DONE. Otherwise → RECV.
  - `imem_addr` increments modulo 2^ADDR_WIDTH. A count of 2^ADDR_WIDTH fills memory exactly and ends with `imem_addr`=0.
- CHECK:
  - `rx_ready`=1; accepts exactly one byte.
  - Byte equals the XOR of all payload bytes → DONE.
  - Otherwise set `error`=1 and go to IDLE with `cpu_reset` still 1. No `done` pulse.
- DONE:
  - One cycle. `done`=1, `busy`=1.
  - Next edge → IDLE with `cpu_reset`=0 and `busy`=0.
- `start` outside IDLE is ignored.
- `start` in IDLE after a successful load reloads the memory and reasserts `cpu_reset` at the edge that enters RECV.
- `reset` mid-load returns all state to reset values. Words already written stay in memory, and a partial word is discarded.

## Timing
- `rx_ready` is a registered function of state; it does not depend combinationally on `rx_valid`.
- Minimum 5 cycles per word (4 accept cycles + 1 WRITE cycle). Back-to-back bytes are accepted every cycle in RECV.
- Load of N words with no stall: `start` edge, then 5N cycles, then [1 CHECK cycle], then 1 DONE cycle. `cpu_reset` falls on the edge after DONE.
- `imem_we` is never high in two consecutive cycles.
- Memory write takes effect at the clock edge ending the WRITE cycle.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - CHECK state is present.
  - One trailing XOR checksum byte is required after the payload.
  - `error` is functional.
- Not defined:
  - No CHECK state; WRITE of the last word → DONE.
  - No trailing byte is consumed.
  - `error` constant 0.

## Test plan
- 2-word load (bytes 20 08 00 05, 21 09 00 07): `start`, `word_count`=2 → writes 0x20080005 @0, 0x21090007 @1. `done` pulses once. `cpu_reset` goes 1→0 after DONE.
- Zero count: `start`, `word_count`=0 → `done` pulse the next cycle. `imem_we` never asserted. `rx_ready` stays 0.
- Backpressure: `rx_valid` toggling with random gaps over 3 words → identical writes and addresses 0,1,2. `imem_we` only in WRITE cycles.
- Checksum (macro defined), 1 word AA BB CC DD:
  - Checksum byte 0x00 → `done` pulses and `cpu_reset`=0.
  - Checksum byte 0x01 → `error`=1, no `done`, `cpu_reset` stays 1.
- Reset after 5 bytes of a 2-word load → word 0 written, no second write. All outputs at reset values, `cpu_reset`=1.
- `start` pulsed during RECV → ignored. The load completes with the originally latched count.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-memory write port between the boot loader and its environment.
// master = loader side (accepts bytes, drives the memory write port); slave = source/memory side.
interface imem_loader_if #(
   parameter int unsigned ADDR_WIDTH = 8
);
   logic [7:0]            rx_data;
   logic                  rx_valid;
   logic                  rx_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [31:0]           imem_wdata;

   modport master (
      input  rx_data, rx_valid,
      output rx_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_data, rx_valid,
      input  rx_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream, writes them to instruction memory and
// holds the core in reset until the load completes. Define IMEM_LOADER_CHECKSUM_EN for a trailing XOR check byte.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_WIDTH:0] word_count,
   imem_loader_if.master       bus,
   output logic                cpu_reset,
   output logic                busy,
   output logic                done,
   output logic                error
);
   localparam int unsigned CNT_W = ADDR_WIDTH + 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t                state, state_n;
   logic [CNT_W-1:0]      count_q, count_n;
   logic [CNT_W-1:0]      written_q, written_n;
   logic [1:0]            byte_idx, byte_idx_n;
   logic [ADDR_WIDTH-1:0] addr_n;
   logic [31:0]           wdata_n;
   logic                  rx_ready_n, we_n, cpu_reset_n, busy_n, done_n;
   logic                  accept_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]            csum_q, csum_n;
   logic                  error_n;
`endif

   assign accept_c = bus.rx_valid && bus.rx_ready;

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= S_IDLE;
         count_q        <= '0;
         written_q      <= '0;
         byte_idx       <= '0;
         bus.rx_ready   <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         cpu_reset      <= 1'b1;
         busy           <= 1'b0;
         done           <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q         <= '0;
         error          <= 1'b0;
`endif
      end else begin
         state          <= state_n;
         count_q        <= count_n;
         written_q      <= written_n;
         byte_idx       <= byte_idx_n;
         bus.rx_ready   <= rx_ready_n;
         bus.imem_we    <= we_n;
         bus.imem_addr  <= addr_n;
         bus.imem_wdata <= wdata_n;
         cpu_reset      <= cpu_reset_n;
         busy           <= busy_n;
         done           <= done_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_q         <= csum_n;
         error          <= error_n;
`endif
      end
   end

`ifndef IMEM_LOADER_CHECKSUM_EN
   assign error = 1'b0;
`endif

   // Next-state and next-output logic; outputs are computed one cycle ahead so they leave flops
   always_comb begin
      state_n     = state;
      count_n     = count_q;
      written_n   = written_q;
      byte_idx_n  = byte_idx;
      addr_n      = bus.imem_addr;
      wdata_n     = bus.imem_wdata;
      cpu_reset_n = cpu_reset;
      busy_n      = busy;
      we_n        = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_n      = csum_q;
      error_n     = error;
`endif

      unique case (state)
         S_IDLE: begin
            if (start) begin
               busy_n = 1'b1;
               if (word_count != '0) begin
                  state_n     = S_RECV;
                  count_n     = word_count;
                  written_n   = '0;
                  addr_n      = '0;
                  byte_idx_n  = '0;
                  cpu_reset_n = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_n      = '0;
                  error_n     = 1'b0;
`endif
               end else begin
                  state_n = S_DONE;
               end
            end
         end

         S_RECV: begin
            if (accept_c) begin
               // Shifting MSB-first leaves byte 0 in [31:24] once four bytes are in
               wdata_n    = {bus.imem_wdata[23:0], bus.rx_data};
               byte_idx_n = 2'(byte_idx + 2'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
               csum_n     = csum_q ^ bus.rx_data;
`endif
               if (byte_idx == 2'd3) begin
                  state_n = S_WRITE;
                  we_n    = 1'b1;
               end
            end
         end

         S_WRITE: begin
            addr_n    = ADDR_WIDTH'(bus.imem_addr + 1'b1);
            written_n = CNT_W'(written_q + 1'b1);
            if (written_n == count_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_n = S_CHECK;
`else
               state_n = S_DONE;
`endif
            end else begin
               state_n = S_RECV;
            end
         end

`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept_c) begin
               if (bus.rx_data == csum_q) begin
                  state_n = S_DONE;
               end else begin
                  state_n = S_IDLE;
                  error_n = 1'b1;
                  busy_n  = 1'b0;
               end
            end
         end
`endif

         S_DONE: begin
            state_n     = S_IDLE;
            cpu_reset_n = 1'b0;
            busy_n      = 1'b0;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase

      rx_ready_n = (state_n == S_RECV) || (state_n == S_CHECK);
      done_n     = (state_n == S_DONE);
   end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected memory writes are queued from the byte payload
// and popped by an independent write monitor. Honors IMEM_LOADER_CHECKSUM_EN when defined.
module tb_imem_loader;
   localparam int unsigned AW = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam int CS_EXTRA = 1;
`else
   localparam int CS_EXTRA = 0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW:0]   word_count;
   logic          cpu_reset, busy, done, error;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .word_count (word_count),
      .bus        (bus.master),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        mon_e;
   logic [7:0] payload[$];
   int         n_pass   = 0;
   int         n_total  = 0;
   int         cyc      = 0;
   int         wr_cnt   = 0;
   int         done_cnt = 0;
   logic       prev_we  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Write monitor: every memory write must match the head of the expected queue
   always @(negedge clk) begin
      if (bus.imem_we) begin
         chk("we_back_to_back", prev_we, 1'b0);
         chk("rx_ready_in_write", bus.rx_ready, 1'b0);
         if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_write: addr=0x%0h data=0x%08h, no write required",
                     bus.imem_addr, bus.imem_wdata);
         end else begin
            mon_e = exp_q.pop_front();
            chk("write_addr", bus.imem_addr, mon_e.addr);
            chk("write_data", bus.imem_wdata, mon_e.data);
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      prev_we <= bus.imem_we;
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_rx_ready"}, bus.rx_ready, 1'b0);
      chk({tag, "_imem_we"}, bus.imem_we, 1'b0);
      chk({tag, "_imem_addr"}, bus.imem_addr, 0);
      chk({tag, "_imem_wdata"}, bus.imem_wdata, 0);
      chk({tag, "_cpu_reset"}, cpu_reset, 1'b1);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
   endtask

   task automatic fill_random(input int n);
      payload.delete();
      for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
   endtask

   // Called at a negedge; returns at the negedge after the byte was taken
   task automatic send_byte(input logic [7:0] b);
      int k = 0;
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      while (!bus.rx_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("rx_ready_wait", bus.rx_ready, 1'b1);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
   endtask

   task automatic do_load(input int n, input int max_gap, input int glitch_at, input bit bad_csum);
      logic [7:0] cs;
      int c0, d0, k;
      cs = 8'h00;
      d0 = done_cnt;
      for (int i = 0; i < n; i++)
         exp_q.push_back('{addr: AW'(i),
                           data: {payload[4*i], payload[4*i+1], payload[4*i+2], payload[4*i+3]}});
      foreach (payload[j]) cs ^= payload[j];

      start      = 1'b1;
      word_count = (AW+1)'(n);
      @(negedge clk);
      start      = 1'b0;
      word_count = (AW+1)'($urandom);
      c0 = cyc;
      chk("busy_at_start", busy, 1'b1);
      chk("cpu_reset_at_start", cpu_reset, 1'b1);
      chk("error_at_start", error, 1'b0);

      for (int j = 0; j < 4 * n; j++) begin
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
         if (j == glitch_at) begin
            start      = 1'b1;
            word_count = (AW+1)'(1);
         end
         send_byte(payload[j]);
         start = 1'b0;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(cs ^ 8'(bad_csum));
`endif

      if (bad_csum) begin
         repeat (3) @(negedge clk);
         chk("csum_error", error, 1'b1);
         chk("csum_cpu_reset", cpu_reset, 1'b1);
         chk("csum_busy", busy, 1'b0);
         chk("csum_no_done", done_cnt - d0, 0);
         chk("csum_writes_left", exp_q.size(), 0);
      end else begin
         k = 0;
         while (!done && k < 50) begin
            @(negedge clk);
            k++;
         end
         chk("done_pulse", done, 1'b1);
         if (max_gap == 0) chk("load_cycles", cyc - c0, 5 * n + CS_EXTRA);
         chk("busy_in_done", busy, 1'b1);
         chk("cpu_reset_in_done", cpu_reset, 1'b1);
         @(negedge clk);
         chk("done_single", done, 1'b0);
         chk("busy_after", busy, 1'b0);
         chk("cpu_reset_released", cpu_reset, 1'b0);
         chk("error_after", error, 1'b0);
         chk("rx_ready_idle", bus.rx_ready, 1'b0);
         chk("done_count", done_cnt - d0, 1);
         chk("writes_left", exp_q.size(), 0);
      end
   endtask

   initial begin
      int n, w0, d0;
      reset        = 1'b1;
      start        = 1'b0;
      word_count   = '0;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_state("por");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_cpu_reset_held", cpu_reset, 1'b1);

      payload = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h21, 8'h09, 8'h00, 8'h07};
      do_load(2, 0, -1, 1'b0);

      // Zero-length load goes straight to DONE
      d0 = done_cnt;
      w0 = wr_cnt;
      start      = 1'b1;
      word_count = '0;
      @(negedge clk);
      start = 1'b0;
      chk("zero_done", done, 1'b1);
      chk("zero_busy", busy, 1'b1);
      chk("zero_rx_ready", bus.rx_ready, 1'b0);
      @(negedge clk);
      chk("zero_done_drop", done, 1'b0);
      chk("zero_rx_ready_idle", bus.rx_ready, 1'b0);
      chk("zero_cpu_reset", cpu_reset, 1'b0);
      chk("zero_no_writes", wr_cnt - w0, 0);
      chk("zero_done_count", done_cnt - d0, 1);

      fill_random(3);
      do_load(3, 3, -1, 1'b0);

      fill_random(3);
      do_load(3, 0, 5, 1'b0);

      repeat (4) begin
         n = $urandom_range(1, 6);
         fill_random(n);
         do_load(n, $urandom_range(0, 3), -1, 1'b0);
      end

      fill_random(1 << AW);
      do_load(1 << AW, 0, -1, 1'b0);
      chk("addr_wrap", bus.imem_addr, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
      payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_load(1, 0, -1, 1'b0);
      payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      do_load(1, 0, -1, 1'b1);
      fill_random(2);
      do_load(2, 1, -1, 1'b0);
`endif

      // Reset after five bytes of a two-word load: only word 0 reaches memory
      fill_random(2);
      exp_q.push_back('{addr: AW'(0), data: {payload[0], payload[1], payload[2], payload[3]}});
      w0 = wr_cnt;
      d0 = done_cnt;
      start      = 1'b1;
      word_count = (AW+1)'(2);
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 5; j++) send_byte(payload[j]);
      reset = 1'b1;
      @(negedge clk);
      check_reset_state("mid_load");
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("mid_load_writes", wr_cnt - w0, 1);
      chk("mid_load_no_done", done_cnt - d0, 0);
      chk("mid_load_rx_ready", bus.rx_ready, 1'b0);
      chk("mid_load_cpu_reset", cpu_reset, 1'b1);
      chk("mid_load_queue", exp_q.size(), 0);

      fill_random(2);
      do_load(2, 1, -1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish within the time limit");
      $fatal(1, "watchdog expired");
   end
endmodule
